verinject_mem_seu_tracker: RTL and testbench
============================================

# verinject_mem_seu_tracker

Persistent single-event-upset model for one memory array. A transient read injector flips a bit only while the injector state points at it. This block instead latches each injected fault into a slot and keeps applying it to every read of that word until the word is rewritten, as a real SEU in a RAM cell behaves. It sits beside a memory instance on its read-data path and snoops the write port. It adds multi-slot tracking, multi-bit upsets, and status outputs.

## Interface
- `LEFT`, 0: left index of the memory word.
- `RIGHT`, 0: right index of the memory word.
- `ADDR_LEFT`, 0: left index of the address vector.
- `ADDR_RIGHT`, 0: right index of the address vector.
- `MEM_LEFT`, 0: left bound of the memory array range.
- `MEM_RIGHT`, 0: right bound of the memory array range.
- `P_START`, 0: first global injector bit number owned by this memory.
- `SLOTS`, 4: number of simultaneously tracked upset words (1..16).
- `MBU_WIDTH`, 1: adjacent bits flipped per fault (1..word_len).
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `verinject__injector_state`  in  32  global fault target bit number; 32'hFFFF_FFFF means no injection.
- `unmodified`  in  [LEFT:RIGHT]  raw memory read data.
- `read_address`  in  [ADDR_LEFT:ADDR_RIGHT]  address of `unmodified`.
- `modified`  out  [LEFT:RIGHT]  read data with tracked upsets applied.
- `do_write`  in  1  memory write strobe.
- `write_address`  in  [ADDR_LEFT:ADDR_RIGHT]  address being written.
- `scrub`  in  1  synchronous clear of all slots.
- `active_count`  out  5  number of valid slots.
- `overflow`  out  1  sticky: a fault was dropped because no slot was free.

## Operation
- word_len = |LEFT-RIGHT|+1. bits_start = min(LEFT,RIGHT). mem_start = min(MEM_LEFT,MEM_RIGHT). mem_len = |MEM_LEFT-MEM_RIGHT|+1. All arithmetic is 32-bit unsigned.
- A fault is in range when P_START ≤ state < P_START + mem_len·word_len.
  - off = state − P_START.
  - addr = mem_start + off / word_len.
  - bit = off % word_len.
  - mask = ((1<<MBU_WIDTH)−1) << bit, truncated at the top of the word with no wrap. Mask bit k maps to vector index bits_start+k.
- Capture is edge-triggered on state change. The previous state is registered; a capture occurs only when the state is in range and differs from the previous value. Holding the state for many cycles yields one capture.
- Each slot has two states, FREE and HELD, and stores addr and mask.
- Capture, in priority order:
  - If a HELD slot has the same addr, XOR the new mask into it. If the result is zero, that slot → FREE.
  - Otherwise the lowest-index FREE slot → HELD with addr and mask.
  - Otherwise drop the fault and set `overflow`.
- When `do_write` is high, every HELD slot whose addr equals `write_address` → FREE.
- Same-cycle write and capture to the same addr: the write clears first, then the capture allocates. The new fault survives on the fresh data.
- `scrub` frees all slots and clears `overflow`. It overrides both write and capture in the same cycle.
- Read path is combinational: `modified` = `unmodified` XOR (OR of the masks of HELD slots whose addr equals `read_address`).
- Reset values:
  - All slots FREE.
  - Previous state = 32'hFFFF_FFFF.
  - `active_count` = 0.
  - `overflow` = 0.
  - `modified` = `unmodified`.

## Timing
- Capture, write-clear and scrub take effect at the rising edge. Reads see the change from the following cycle; there is zero same-cycle bypass.
- Read latency is 0 cycles, combinational from `unmodified`/`read_address` to `modified`.
- `active_count` and `overflow` are registered and update together with the slot state.
- Reset asserted mid-operation discards every slot immediately and asynchronously. `modified` passes data through during reset.

## Structure
- Shared package `verinject_pkg`:
  - constant `VERINJECT_NO_INJECTION` = 32'hFFFF_FFFF.
  - range/offset helper functions: word_len, bits_start, span.
- Sub-module `verinject_mem_seu_slot`: one slot holding its FREE/HELD state, addr and mask. It has capture-match, write-match and read-match compare outputs. The top instantiates `SLOTS` copies and contains the priority allocator, the edge detector and the read XOR tree.

## Test plan
Default configuration for all scenarios: LEFT=7, RIGHT=0, ADDR 3:0, MEM 0:15, P_START=100, SLOTS=2, MBU_WIDTH=1.
- Single fault:
  - Stimulus: state=129 for 1 cycle, then 32'hFFFF_FFFF; read addr 3 with data 0x00.
  - Required: `modified`=0x20 from the next cycle and persisting; addr 4 reads pass unchanged; `active_count`=1.
- Write clears:
  - Stimulus: after the single-fault scenario, `do_write` to addr 3.
  - Required: the next read of addr 3 returns raw data; `active_count`=0.
- Held state:
  - Stimulus: state=129 held for 5 cycles.
  - Required: `active_count`=1 and `modified`=0x20 on addr 3, not toggling.
- Overflow:
  - Stimulus: faults at 129, 140 and 150.
  - Required: `active_count`=2, `overflow`=1, addr 6 (state 150) unaffected; `scrub` → count 0, `overflow` 0.
- Cancellation:
  - Stimulus: state 129, then idle, then 129 again.
  - Required: the mask cancels; `active_count`=0 and addr 3 reads unchanged.
- MBU truncation and reset:
  - Stimulus: MBU_WIDTH=2, state=131.
  - Required: addr 3 gets only bit 7 flipped (0x80); asserting `reset_n`=0 asynchronously → `modified`=`unmodified`, count 0.

Source files
------------

// File: rtl/verinject_mem_seu_tracker_pkg.sv
// Shared constants, slot state type and range helpers for the persistent SEU tracker.
package verinject_pkg;

  localparam logic [31:0] VERINJECT_NO_INJECTION = 32'hFFFF_FFFF;

  typedef enum logic {
    SLOT_FREE = 1'b0,
    SLOT_HELD = 1'b1
  } slot_state_t;

  function automatic int unsigned word_len(input int l, input int r);
    return (l > r) ? unsigned'(l - r + 1) : unsigned'(r - l + 1);
  endfunction

  function automatic int unsigned bits_start(input int l, input int r);
    return (l < r) ? unsigned'(l) : unsigned'(r);
  endfunction

  function automatic int unsigned span(input int unsigned words, input int unsigned wl);
    return words * wl;
  endfunction

endpackage

// File: rtl/verinject_mem_seu_slot.sv
// One tracked upset: FREE/HELD state plus the word address and flip mask it applies.
module verinject_mem_seu_slot
  import verinject_pkg::*;
#(
  parameter int unsigned AW = 4,
  parameter int unsigned WL = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          alloc,
  input  logic          toggle,
  input  logic          drop,
  input  logic [AW-1:0] fault_addr,
  input  logic [WL-1:0] fault_mask,
  input  logic [AW-1:0] write_addr,
  input  logic [AW-1:0] read_addr,
  output logic          held,
  output logic          held_next,
  output logic          capture_match,
  output logic          write_match,
  output logic          read_match,
  output logic [WL-1:0] mask
);

  slot_state_t   state, state_next;
  logic [AW-1:0] addr, addr_next;
  logic [WL-1:0] mask_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= SLOT_FREE;
      addr  <= '0;
      mask  <= '0;
    end else begin
      state <= state_next;
      addr  <= addr_next;
      mask  <= mask_next;
    end
  end

  // alloc outranks drop so a write-cleared slot can take the fresh fault in the same cycle
  always_comb begin
    state_next = state;
    addr_next  = addr;
    mask_next  = mask;
    case (state)
      SLOT_FREE: begin
        if (alloc) begin
          state_next = SLOT_HELD;
          addr_next  = fault_addr;
          mask_next  = fault_mask;
        end
      end
      SLOT_HELD: begin
        if (alloc) begin
          addr_next = fault_addr;
          mask_next = fault_mask;
        end else if (toggle) begin
          mask_next = mask ^ fault_mask;
          if (mask_next == '0) state_next = SLOT_FREE;
        end else if (drop) begin
          state_next = SLOT_FREE;
        end
      end
      default: state_next = SLOT_FREE;
    endcase
  end

  always_comb begin
    held          = (state == SLOT_HELD);
    held_next     = (state_next == SLOT_HELD);
    capture_match = held && (addr == fault_addr);
    write_match   = held && (addr == write_addr);
    read_match    = held && (addr == read_addr);
  end

endmodule

// File: rtl/verinject_mem_seu_tracker.sv
// Persistent SEU model: latches injected faults into slots and applies them to every
// read of the word until that word is rewritten or the tracker is scrubbed.
module verinject_mem_seu_tracker
  import verinject_pkg::*;
#(
  parameter int          LEFT       = 0,
  parameter int          RIGHT      = 0,
  parameter int          ADDR_LEFT  = 0,
  parameter int          ADDR_RIGHT = 0,
  parameter int          MEM_LEFT   = 0,
  parameter int          MEM_RIGHT  = 0,
  parameter int unsigned P_START    = 0,
  parameter int unsigned SLOTS      = 4,
  parameter int unsigned MBU_WIDTH  = 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [31:0]                  verinject__injector_state,
  input  logic [LEFT:RIGHT]            unmodified,
  input  logic [ADDR_LEFT:ADDR_RIGHT]  read_address,
  output logic [LEFT:RIGHT]            modified,
  input  logic                         do_write,
  input  logic [ADDR_LEFT:ADDR_RIGHT]  write_address,
  input  logic                         scrub,
  output logic [4:0]                   active_count,
  output logic                         overflow
);

  localparam int unsigned WL        = word_len(LEFT, RIGHT);
  localparam int unsigned BS        = bits_start(LEFT, RIGHT);
  localparam int unsigned AW        = word_len(ADDR_LEFT, ADDR_RIGHT);
  localparam int unsigned MEM_START = bits_start(MEM_LEFT, MEM_RIGHT);
  localparam int unsigned MEM_LEN   = word_len(MEM_LEFT, MEM_RIGHT);
  localparam int unsigned SPAN      = span(MEM_LEN, WL);

  logic [31:0]      prev_state, offset, fault_bit;
  logic             capture, any_hit, found, overflow_set;
  logic [AW-1:0]    cap_addr;
  logic [WL-1:0]    cap_mask, read_mask;
  logic [SLOTS-1:0] held, held_next, cap_hit, wr_hit, rd_hit, alloc, toggle, drop;
  logic [WL-1:0]    slot_mask [SLOTS];
  logic [4:0]       next_count;

  always_comb begin
    offset    = verinject__injector_state - P_START;
    capture   = (verinject__injector_state >= P_START) && (offset < SPAN)
                && (verinject__injector_state != prev_state);
    cap_addr  = AW'(MEM_START + offset / WL);
    fault_bit = offset % WL;
    cap_mask  = '0;
    for (int unsigned k = 0; k < WL; k++) begin
      cap_mask[k] = (k >= fault_bit) && (k < fault_bit + MBU_WIDTH);
    end
  end

  // Write-clears are resolved before capture, so a slot being cleared counts as free.
  always_comb begin
    alloc        = '0;
    toggle       = '0;
    drop         = '0;
    any_hit      = 1'b0;
    found        = 1'b0;
    overflow_set = 1'b0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      drop[i] = scrub || (do_write && wr_hit[i]);
    end
    if (!scrub && capture) begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        if (cap_hit[i] && !drop[i]) begin
          toggle[i] = 1'b1;
          any_hit   = 1'b1;
        end
      end
      if (!any_hit) begin
        for (int unsigned i = 0; i < SLOTS; i++) begin
          if (!found && (!held[i] || drop[i])) begin
            alloc[i] = 1'b1;
            found    = 1'b1;
          end
        end
        overflow_set = !found;
      end
    end
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    verinject_mem_seu_slot #(
      .AW (AW),
      .WL (WL)
    ) u_slot (
      .clock         (clock),
      .reset_n       (reset_n),
      .alloc         (alloc[g]),
      .toggle        (toggle[g]),
      .drop          (drop[g]),
      .fault_addr    (cap_addr),
      .fault_mask    (cap_mask),
      .write_addr    (write_address),
      .read_addr     (read_address),
      .held          (held[g]),
      .held_next     (held_next[g]),
      .capture_match (cap_hit[g]),
      .write_match   (wr_hit[g]),
      .read_match    (rd_hit[g]),
      .mask          (slot_mask[g])
    );
  end

  always_comb begin
    next_count = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      next_count = next_count + {4'b0, held_next[i]};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_state   <= VERINJECT_NO_INJECTION;
      active_count <= '0;
      overflow     <= 1'b0;
    end else begin
      prev_state   <= verinject__injector_state;
      active_count <= next_count;
      overflow     <= scrub ? 1'b0 : (overflow | overflow_set);
    end
  end

  always_comb begin
    read_mask = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (rd_hit[i]) read_mask = read_mask | slot_mask[i];
    end
    modified = unmodified;
    for (int unsigned k = 0; k < WL; k++) begin
      modified[BS + k] = unmodified[BS + k] ^ read_mask[k];
    end
  end

endmodule

// File: tb/tb_verinject_mem_seu_tracker.sv
// Randomized self-checking bench: two trackers (MBU width 1 and 2) against a queue-based fault model.
module tb_verinject_mem_seu_tracker;

  localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] state = IDLE;
  logic [7:0]  data = 8'h00;
  logic [3:0]  raddr = 4'd0;
  logic [3:0]  waddr = 4'd0;
  logic        we = 1'b0;
  logic        scrub = 1'b0;
  logic [7:0]  mod1, mod2;
  logic [4:0]  cnt1, cnt2;
  logic        ovf1, ovf2;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int unsigned m;
    logic [3:0]  addr;
    logic [7:0]  mask;
  } fault_t;

  fault_t      faults[$];
  logic [31:0] model_prev = IDLE;
  bit          model_ovf[2];

  always #5 clock = ~clock;

  verinject_mem_seu_tracker #(
    .LEFT(7), .RIGHT(0), .ADDR_LEFT(3), .ADDR_RIGHT(0), .MEM_LEFT(0), .MEM_RIGHT(15),
    .P_START(100), .SLOTS(2), .MBU_WIDTH(1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .verinject__injector_state(state),
    .unmodified(data), .read_address(raddr), .modified(mod1), .do_write(we),
    .write_address(waddr), .scrub(scrub), .active_count(cnt1), .overflow(ovf1)
  );

  verinject_mem_seu_tracker #(
    .LEFT(7), .RIGHT(0), .ADDR_LEFT(3), .ADDR_RIGHT(0), .MEM_LEFT(0), .MEM_RIGHT(15),
    .P_START(100), .SLOTS(2), .MBU_WIDTH(2)
  ) dut2 (
    .clock(clock), .reset_n(reset_n), .verinject__injector_state(state),
    .unmodified(data), .read_address(raddr), .modified(mod2), .do_write(we),
    .write_address(waddr), .scrub(scrub), .active_count(cnt2), .overflow(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model index m flips m+1 adjacent bits per fault.
  function automatic logic [7:0] model_mask(input int unsigned m, input logic [31:0] s);
    logic [31:0] full;
    full = ((32'd1 << (m + 1)) - 32'd1) << ((s - 32'd100) % 32'd8);
    return full[7:0];
  endfunction

  function automatic logic [7:0] model_read(input int unsigned m, input logic [3:0] a);
    logic [7:0] r;
    r = 8'h00;
    foreach (faults[i]) if (faults[i].m == m && faults[i].addr == a) r = r | faults[i].mask;
    return r;
  endfunction

  function automatic int model_count(input int unsigned m);
    int c;
    c = 0;
    foreach (faults[i]) if (faults[i].m == m) c++;
    return c;
  endfunction

  task automatic model_reset();
    faults.delete();
    model_prev = IDLE;
    model_ovf[0] = 1'b0;
    model_ovf[1] = 1'b0;
  endtask

  task automatic model_step();
    bit          cap;
    logic [31:0] off;
    off = state - 32'd100;
    cap = (state >= 32'd100) && (off < 32'd128) && (state != model_prev);
    model_prev = state;
    if (scrub) begin
      faults.delete();
      model_ovf[0] = 1'b0;
      model_ovf[1] = 1'b0;
      return;
    end
    if (we) begin
      for (int i = faults.size() - 1; i >= 0; i--) if (faults[i].addr == waddr) faults.delete(i);
    end
    if (cap) begin
      for (int unsigned m = 0; m < 2; m++) begin
        logic [3:0] a;
        logic [7:0] mk;
        bit         hit;
        fault_t     f;
        a   = 4'(off / 32'd8);
        mk  = model_mask(m, state);
        hit = 1'b0;
        for (int i = 0; i < faults.size(); i++) begin
          if (!hit && faults[i].m == m && faults[i].addr == a) begin
            hit = 1'b1;
            f = faults[i];
            f.mask = f.mask ^ mk;
            if (f.mask == 8'h00) faults.delete(i);
            else faults[i] = f;
            break;
          end
        end
        if (!hit) begin
          if (model_count(m) < 2) faults.push_back('{m, a, mk});
          else model_ovf[m] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("mod_mbu1", 32'(mod1), 32'(data ^ model_read(0, raddr)));
    check("mod_mbu2", 32'(mod2), 32'(data ^ model_read(1, raddr)));
    check("count_mbu1", 32'(cnt1), 32'(model_count(0)));
    check("count_mbu2", 32'(cnt2), 32'(model_count(1)));
    check("ovf_mbu1", 32'(ovf1), 32'(model_ovf[0]));
    check("ovf_mbu2", 32'(ovf2), 32'(model_ovf[1]));
  endtask

  task automatic drive(input logic [31:0] s, input logic w, input logic [3:0] wa,
                       input logic sc, input logic [3:0] ra, input logic [7:0] d);
    @(negedge clock);
    state = s; we = w; waddr = wa; scrub = sc; raddr = ra; data = d;
    #1;
    check_outputs();
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
  endtask

  task automatic cycle(input logic [31:0] s, input logic w, input logic [3:0] wa,
                       input logic sc, input logic [3:0] ra, input logic [7:0] d);
    drive(s, w, wa, sc, ra, d);
    tick();
  endtask

  initial begin
    model_reset();
    raddr = 4'd3;
    data  = 8'hA5;
    #12;
    check("reset_mod", 32'(mod1), 32'h0000_00A5);
    check("reset_count", 32'(cnt1), 32'd0);
    check("reset_ovf", 32'(ovf1), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // single fault, persistence, neighbour word
    cycle(32'd129, 0, 0, 0, 3, 8'h00);
    drive(IDLE, 0, 0, 0, 3, 8'h00);
    check("single_a3", 32'(mod1), 32'h20);
    check("single_count", 32'(cnt1), 32'd1);
    tick();
    drive(IDLE, 0, 0, 0, 4, 8'h00);
    check("single_a4", 32'(mod1), 32'h00);
    tick();
    drive(IDLE, 0, 0, 0, 3, 8'h0F);
    check("persist_a3", 32'(mod1), 32'h2F);
    tick();

    // write clears
    cycle(IDLE, 1, 3, 0, 3, 8'h0F);
    drive(IDLE, 0, 0, 0, 3, 8'h0F);
    check("wclr_a3", 32'(mod1), 32'h0F);
    check("wclr_count", 32'(cnt1), 32'd0);
    tick();

    // held state yields one capture
    repeat (5) cycle(32'd129, 0, 0, 0, 3, 8'h00);
    drive(IDLE, 0, 0, 0, 3, 8'h00);
    check("held_a3", 32'(mod1), 32'h20);
    check("held_count", 32'(cnt1), 32'd1);
    tick();

    // cancellation
    cycle(32'd129, 0, 0, 0, 3, 8'h33);
    drive(IDLE, 0, 0, 0, 3, 8'h33);
    check("cancel_a3", 32'(mod1), 32'h33);
    check("cancel_count", 32'(cnt1), 32'd0);
    tick();

    // overflow then scrub
    cycle(32'd129, 0, 0, 0, 6, 8'h11);
    cycle(32'd140, 0, 0, 0, 6, 8'h11);
    cycle(32'd150, 0, 0, 0, 6, 8'h11);
    drive(IDLE, 0, 0, 0, 6, 8'h11);
    check("ovf_a6", 32'(mod1), 32'h11);
    check("ovf_count", 32'(cnt1), 32'd2);
    check("ovf_flag", 32'(ovf1), 32'd1);
    tick();
    cycle(IDLE, 1, 3, 1, 3, 8'h00);
    drive(IDLE, 0, 0, 0, 3, 8'h00);
    check("scrub_count", 32'(cnt1), 32'd0);
    check("scrub_ovf", 32'(ovf1), 32'd0);
    check("scrub_a3", 32'(mod1), 32'h00);
    tick();

    // range boundaries
    cycle(32'd99, 0, 0, 0, 0, 8'h00);
    cycle(32'd228, 0, 0, 0, 0, 8'h00);
    cycle(32'd100, 0, 0, 0, 0, 8'h00);
    cycle(32'd227, 0, 0, 0, 0, 8'h00);
    drive(IDLE, 0, 0, 0, 15, 8'h00);
    check("top_bit_mbu1", 32'(mod1), 32'h80);
    check("top_bit_mbu2", 32'(mod2), 32'h80);
    tick();
    drive(IDLE, 0, 0, 0, 0, 8'h00);
    check("bottom_bit", 32'(mod1), 32'h01);
    tick();

    // same-cycle write and capture to one word
    cycle(IDLE, 0, 0, 1, 3, 8'h00);
    cycle(32'd129, 0, 0, 0, 3, 8'h00);
    cycle(IDLE, 0, 0, 0, 3, 8'h00);
    cycle(32'd129, 1, 3, 0, 3, 8'h00);
    drive(IDLE, 0, 0, 0, 3, 8'h00);
    check("wr_cap_a3", 32'(mod1), 32'h20);
    check("wr_cap_count", 32'(cnt1), 32'd1);
    tick();

    // MBU truncation, then asynchronous reset
    cycle(IDLE, 0, 0, 1, 3, 8'h00);
    cycle(32'd131, 0, 0, 0, 3, 8'h00);
    drive(IDLE, 0, 0, 0, 3, 8'h00);
    check("mbu_trunc", 32'(mod2), 32'h80);
    tick();
    @(negedge clock);
    data = 8'h5A;
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_mod", 32'(mod2), 32'h5A);
    check("async_rst_count", 32'(cnt2), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    for (int n = 0; n < 600; n++) begin
      logic [31:0] s;
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 3) s = IDLE;
      else if (r < 4) s = state;
      else if (r < 8) s = $urandom_range(95, 140);
      else s = $urandom_range(95, 232);
      cycle(s, ($urandom_range(0, 4) == 0), 4'($urandom_range(0, 5)),
            ($urandom_range(0, 39) == 0), 4'($urandom_range(0, 5)), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
